// File: rtl/i2c_target_core.sv
// I2C target engine: START/STOP decode, 7-bit address match, byte streaming over valid/ready ports.
// Define I2C_TARGET_STRETCH_EN to stretch SCL on full rx buffer / empty tx instead of NACK / 0xFF.
module i2c_target_core #(
  parameter int FILTER_LEN  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] own_addr,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       overrun,
  output logic       underrun
);
`ifdef I2C_TARGET_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD = HOLD_CYCLES[HW-1:0];

  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK,
                            RD_LOAD, RD_DATA, RD_ACK, IGNORE} state_t;

  state_t                state;
  logic [1:0]            scl_s, sda_s;
  logic [FILTER_LEN-1:0] scl_h, sda_h;
  logic                  scl_f, sda_f, scl_q, sda_q;
  logic [7:0]            sr;
  logic [3:0]            cnt;
  logic [HW-1:0]         hold_cnt;
  logic                  pend, wait_q, en_lat, first_pend;
  logic [6:0]            addr_lat;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  // Lines idle high, so the front end resets to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s <= '1; sda_s <= '1; scl_h <= '1; sda_h <= '1;
      scl_f <= 1'b1; sda_f <= 1'b1; scl_q <= 1'b1; sda_q <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_h <= {scl_h[FILTER_LEN-2:0], scl_s[1]};
      sda_h <= {sda_h[FILTER_LEN-2:0], sda_s[1]};
      if (&scl_h) scl_f <= 1'b1; else if (!(|scl_h)) scl_f <= 1'b0;
      if (&sda_h) sda_f <= 1'b1; else if (!(|sda_h)) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c, rx_free;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_free  = ~rx_valid | rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; sr <= '0; cnt <= '0; hold_cnt <= '0;
      pend <= 1'b0; wait_q <= 1'b0; en_lat <= 1'b0; first_pend <= 1'b0; addr_lat <= '0;
      scl_oen_o <= 1'b1; sda_oen_o <= 1'b1;
      rx_data <= '0; rx_valid <= 1'b0; rx_first <= 1'b0; tx_ready <= 1'b0;
      busy <= 1'b0; rw <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0;
      overrun <= 1'b0; underrun <= 1'b0;
    end else begin
      tx_ready <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0;
      overrun <= 1'b0; underrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // SDA only moves HOLD cycles after SCL fall (or after a stretch ends); SCL released with it.
      if (scl_fall) hold_cnt <= HOLD;
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (hold_cnt == HW'(1)) begin
        sda_oen_o <= ~pend;
        if (!wait_q) scl_oen_o <= 1'b1;
      end
      if (start_c || stop_c) begin
        state <= start_c ? ADDR : IDLE;
        start_det <= start_c; stop_det <= stop_c;
        if (stop_c) busy <= 1'b0;
        cnt <= '0; pend <= 1'b0; wait_q <= 1'b0; hold_cnt <= '0;
        sda_oen_o <= 1'b1; scl_oen_o <= 1'b1;
        en_lat <= enable; addr_lat <= own_addr;
      end else begin
        case (state)
          ADDR, WR_DATA: begin
            if (scl_rise && cnt != 4'd8) begin
              sr  <= {sr[6:0], sda_f};
              cnt <= cnt + 1'b1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              if (state == ADDR) begin
                if (en_lat && sr[7:1] == addr_lat) begin
                  state <= ADDR_ACK; pend <= 1'b1; rw <= sr[0];
                  busy <= 1'b1; first_pend <= ~sr[0];
                end else begin
                  state <= IGNORE; busy <= 1'b0;
                end
              end else if (rx_free) begin
                rx_data <= sr; rx_valid <= 1'b1; rx_first <= first_pend;
                first_pend <= 1'b0; pend <= 1'b1; state <= WR_ACK;
              end else if (STRETCH) begin
                state <= WR_ACK; wait_q <= 1'b1; scl_oen_o <= 1'b0;
              end else begin
                overrun <= 1'b1; state <= IGNORE; busy <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            pend  <= 1'b0;
            state <= rw ? RD_LOAD : WR_DATA;
          end
          WR_ACK: begin
            if (wait_q) begin
              if (rx_free) begin
                rx_data <= sr; rx_valid <= 1'b1; rx_first <= first_pend;
                first_pend <= 1'b0; pend <= 1'b1; wait_q <= 1'b0; hold_cnt <= HOLD;
              end
            end else if (scl_fall) begin
              pend <= 1'b0; state <= WR_DATA;
            end
          end
          RD_LOAD: begin
            if (tx_valid) begin
              sr <= tx_data; tx_ready <= 1'b1; pend <= ~tx_data[7]; state <= RD_DATA;
              if (wait_q) begin
                wait_q <= 1'b0; hold_cnt <= HOLD;
              end
            end else if (STRETCH) begin
              wait_q <= 1'b1; scl_oen_o <= 1'b0;
            end else begin
              sr <= 8'hFF; pend <= 1'b0; underrun <= 1'b1; state <= RD_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (cnt == 4'd7) begin
              cnt <= '0; pend <= 1'b0; state <= RD_ACK;
            end else begin
              sr <= {sr[6:0], 1'b0}; pend <= ~sr[6]; cnt <= cnt + 1'b1;
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_f) begin
              state <= IGNORE; busy <= 1'b0;
            end else if (scl_fall) begin
              state <= RD_LOAD;
            end
          end
          IDLE, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
